// File: rtl/obek_getirici.sv
// obek_getirici: instruction-cache block refill engine.
// On a miss request it reads four 32-bit words from main memory, one at a
// time, and assembles them into a 128-bit block for the cache. A per-word
// timeout aborts a refill that stops receiving data.
//
// Build option:
//   KRITIK_KELIME_ILK_EN  - when defined, the fetch starts at the missed word
//                           (istek_adres_i[3:2]) and wraps modulo 4
//                           (critical word first). When undefined, words are
//                           fetched 0,1,2,3. Block layout is identical either way.
module obek_getirici #(
    parameter int ZAMAN_ASIMI = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         istek_i,
    input  logic [31:0]  istek_adres_i,
    output logic         bellek_oku_o,
    output logic [31:0]  bellek_adres_o,
    input  logic [31:0]  bellek_veri_i,
    input  logic         bellek_gecerli_i,
    output logic [127:0] buyruk_obek_o,
    output logic         obek_geldi_o,
    output logic [31:0]  onbellek_yaz_adres_o,
    output logic         mesgul_o,
    output logic         hata_o
);

    // Timeout counter just wide enough to hold ZAMAN_ASIMI.
    localparam int TW = (ZAMAN_ASIMI < 2) ? 1 : $clog2(ZAMAN_ASIMI + 1);
    // Last count value before the wait limit is reached.
    localparam logic [TW-1:0] SINIR = TW'(ZAMAN_ASIMI - 1);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        OKU   = 2'd1,
        TAMAM = 2'd2,
        HATA  = 2'd3
    } durum_t;

    durum_t          durum_r;
    logic [27:0]     taban_r;        // block base address bits [31:4]
    logic [1:0]      kelime_idx_r;   // slot of the word currently being read
    logic [1:0]      alinan_r;       // number of words captured so far
    logic [TW-1:0]   zaman_r;        // idle cycles waiting for current word
    logic [127:0]    parca_r;        // partially assembled block
    logic [127:0]    obek_r;         // last completed block
    logic [31:0]     yaz_adres_r;    // block address of last completed block
    logic            oku_r;
    logic [31:0]     adres_r;
    logic            geldi_r;
    logic            mesgul_r;
    logic            hata_r;

    logic [1:0]      baslangic_idx_s;
    logic [1:0]      sonraki_idx_s;
    logic            yakala_s;
    logic            son_kelime_s;
    logic            zaman_doldu_s;
    logic [127:0]    birlesik_s;
    logic            unused_s;

    // Low address bits only select the starting word (or nothing at all).
    assign unused_s = ^istek_adres_i[3:0];

`ifdef KRITIK_KELIME_ILK_EN
    // Critical word first: begin with the word that actually missed.
    assign baslangic_idx_s = istek_adres_i[3:2];
`else
    // Sequential fetch: always begin with word 0 of the block.
    assign baslangic_idx_s = 2'd0;
`endif

    // Capture / completion / timeout decode for the current OKU cycle.
    always_comb begin
        sonraki_idx_s = kelime_idx_r + 2'd1;
        if (durum_r == OKU) begin
            yakala_s      = bellek_gecerli_i;
            son_kelime_s  = bellek_gecerli_i && (alinan_r == 2'd3);
            zaman_doldu_s = !bellek_gecerli_i && (zaman_r == SINIR);
        end else begin
            yakala_s      = 1'b0;
            son_kelime_s  = 1'b0;
            zaman_doldu_s = 1'b0;
        end
    end

    // Merge the incoming word into its address slot of the partial block.
    always_comb begin
        birlesik_s = parca_r;
        case (kelime_idx_r)
            2'd0:    birlesik_s[31:0]   = bellek_veri_i;
            2'd1:    birlesik_s[63:32]  = bellek_veri_i;
            2'd2:    birlesik_s[95:64]  = bellek_veri_i;
            2'd3:    birlesik_s[127:96] = bellek_veri_i;
            default: birlesik_s         = parca_r;
        endcase
    end

    // Refill state machine with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_r      <= BOSTA;
            taban_r      <= 28'd0;
            kelime_idx_r <= 2'd0;
            alinan_r     <= 2'd0;
            zaman_r      <= '0;
            parca_r      <= 128'd0;
            obek_r       <= 128'd0;
            yaz_adres_r  <= 32'd0;
            oku_r        <= 1'b0;
            adres_r      <= 32'd0;
            geldi_r      <= 1'b0;
            mesgul_r     <= 1'b0;
            hata_r       <= 1'b0;
        end else begin
            case (durum_r)
                BOSTA: begin
                    geldi_r <= 1'b0;
                    hata_r  <= 1'b0;
                    if (istek_i) begin
                        taban_r      <= istek_adres_i[31:4];
                        kelime_idx_r <= baslangic_idx_s;
                        alinan_r     <= 2'd0;
                        zaman_r      <= '0;
                        parca_r      <= 128'd0;
                        oku_r        <= 1'b1;
                        adres_r      <= {istek_adres_i[31:4], baslangic_idx_s, 2'b00};
                        mesgul_r     <= 1'b1;
                        durum_r      <= OKU;
                    end else begin
                        oku_r    <= 1'b0;
                        mesgul_r <= 1'b0;
                        durum_r  <= BOSTA;
                    end
                end

                OKU: begin
                    if (yakala_s) begin
                        parca_r      <= birlesik_s;
                        zaman_r      <= '0;
                        alinan_r     <= alinan_r + 2'd1;
                        kelime_idx_r <= sonraki_idx_s;
                        if (son_kelime_s) begin
                            // Fourth word: publish the block and release memory.
                            obek_r      <= birlesik_s;
                            yaz_adres_r <= {taban_r, 4'b0000};
                            geldi_r     <= 1'b1;
                            oku_r       <= 1'b0;
                            durum_r     <= TAMAM;
                        end else begin
                            // Index wraps inside the block; base bits never change.
                            adres_r <= {taban_r, sonraki_idx_s, 2'b00};
                            durum_r <= OKU;
                        end
                    end else if (zaman_doldu_s) begin
                        // Memory went silent: drop the partial block.
                        parca_r <= 128'd0;
                        hata_r  <= 1'b1;
                        oku_r   <= 1'b0;
                        durum_r <= HATA;
                    end else begin
                        zaman_r <= zaman_r + TW'(1);
                        durum_r <= OKU;
                    end
                end

                TAMAM: begin
                    geldi_r  <= 1'b0;
                    mesgul_r <= 1'b0;
                    durum_r  <= BOSTA;
                end

                HATA: begin
                    hata_r   <= 1'b0;
                    mesgul_r <= 1'b0;
                    durum_r  <= BOSTA;
                end

                default: begin
                    oku_r    <= 1'b0;
                    geldi_r  <= 1'b0;
                    hata_r   <= 1'b0;
                    mesgul_r <= 1'b0;
                    durum_r  <= BOSTA;
                end
            endcase
        end
    end

    assign bellek_oku_o         = oku_r;
    assign bellek_adres_o       = adres_r;
    assign buyruk_obek_o        = obek_r;
    assign obek_geldi_o         = geldi_r;
    assign onbellek_yaz_adres_o = yaz_adres_r;
    assign mesgul_o             = mesgul_r;
    assign hata_o               = hata_r;

endmodule

// File: tb/tb_obek_getirici.sv
// Testbench for obek_getirici: table of directed refills plus hand-written
// sequences for held requests and reset in the middle of a refill.
// "Cycle N+k" below is the clock cycle closed by edge N+k, where edge N is
// the edge that accepts istek_i. Works with or without KRITIK_KELIME_ILK_EN.
module tb_obek_getirici;

    logic         clk_i;
    logic         rst_i;
    logic         istek_i;
    logic [31:0]  istek_adres_i;
    logic         bellek_oku_o;
    logic [31:0]  bellek_adres_o;
    logic [31:0]  bellek_veri_i;
    logic         bellek_gecerli_i;
    logic [127:0] buyruk_obek_o;
    logic         obek_geldi_o;
    logic [31:0]  onbellek_yaz_adres_o;
    logic         mesgul_o;
    logic         hata_o;

    int checks;
    int failures;

    obek_getirici #(.ZAMAN_ASIMI(8)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .istek_i              (istek_i),
        .istek_adres_i        (istek_adres_i),
        .bellek_oku_o         (bellek_oku_o),
        .bellek_adres_o       (bellek_adres_o),
        .bellek_veri_i        (bellek_veri_i),
        .bellek_gecerli_i     (bellek_gecerli_i),
        .buyruk_obek_o        (buyruk_obek_o),
        .obek_geldi_o         (obek_geldi_o),
        .onbellek_yaz_adres_o (onbellek_yaz_adres_o),
        .mesgul_o             (mesgul_o),
        .hata_o               (hata_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0]      adr;    // request address
        int               gap;    // idle cycles before each valid word
        int               stop;   // words memory returns before going silent
        logic [3:0][31:0] ea;     // expected memory address for word 0..3
        logic [127:0]     eobek;  // expected buyruk_obek_o afterwards
        logic [31:0]      eyaz;   // expected onbellek_yaz_adres_o afterwards
        int               eat;    // expected pulse cycle, relative to N
        int               egel;   // expected number of obek_geldi_o pulses
        int               ehata;  // expected number of hata_o pulses
    } vec_t;

    vec_t vt [7];

    localparam logic [127:0] OBEK_A = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};

    // Main memory contents: block 0x1230 holds 0xA0..0xA3, all else addr^0xC0DE0000.
    function automatic logic [31:0] mem(input logic [31:0] a);
        logic [31:0] r;
        if (a[31:4] == 28'h000_0123) r = 32'h0000_00A0 + {30'd0, a[3:2]};
        else                         r = a ^ 32'hC0DE_0000;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [31:0] adr, input int gap, input int stop,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3,
                           input logic [127:0] eobek, input logic [31:0] eyaz,
                           input int eat, input int egel, input int ehata);
        vt[i].adr = adr;  vt[i].gap = gap;  vt[i].stop = stop;
        vt[i].ea[0] = a0; vt[i].ea[1] = a1; vt[i].ea[2] = a2; vt[i].ea[3] = a3;
        vt[i].eobek = eobek; vt[i].eyaz = eyaz;
        vt[i].eat = eat; vt[i].egel = egel; vt[i].ehata = ehata;
    endtask

    // Issue one refill, act as memory, and check addresses, pulses and results.
    task automatic do_refill(input vec_t v, input bit hold, input string tag);
        int  e, wg, idle, seen_at, gcnt, hcnt;
        bit  done, fin;
        istek_adres_i = v.adr;
        istek_i       = 1'b1;
        tick();                               // edge N
        if (!hold) istek_i = 1'b0;
        e = 0; wg = 0; idle = 0; seen_at = -1; gcnt = 0; hcnt = 0;
        done = 1'b0; fin = 1'b0;
        for (int k = 0; k < 80; k++) begin
            gcnt += int'(obek_geldi_o);
            hcnt += int'(hata_o);
            if (done) begin
                chk({tag, ".mesgul_after"}, 128'(mesgul_o), 128'd0);
                fin = 1'b1;
                break;
            end else if (obek_geldi_o || hata_o) begin
                seen_at = e + 1;
                done    = 1'b1;
                bellek_gecerli_i = 1'b0;
                chk({tag, ".oku_at_pulse"}, 128'(bellek_oku_o), 128'd0);
                chk({tag, ".mesgul_at_pulse"}, 128'(mesgul_o), 128'd1);
            end else begin
                chk({tag, ".oku"}, 128'(bellek_oku_o), 128'd1);
                if (wg < 4) chk({tag, ".adres"}, 128'(bellek_adres_o), 128'(v.ea[wg]));
                if (wg < v.stop && idle == v.gap) begin
                    bellek_gecerli_i = 1'b1;
                    bellek_veri_i    = mem(bellek_adres_o);
                    wg++;
                    idle = 0;
                end else begin
                    bellek_gecerli_i = 1'b0;
                    bellek_veri_i    = 32'hDEAD_BEEF;
                    idle++;
                end
            end
            tick();
            e++;
        end
        bellek_gecerli_i = 1'b0;
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL %s.budget refill never finished within 80 cycles", tag);
        end
        chk({tag, ".pulse_cycle"}, 128'(seen_at), 128'(v.eat));
        chk({tag, ".geldi_count"}, 128'(gcnt), 128'(v.egel));
        chk({tag, ".hata_count"}, 128'(hcnt), 128'(v.ehata));
        chk({tag, ".obek"}, buyruk_obek_o, v.eobek);
        chk({tag, ".yaz_adres"}, 128'(onbellek_yaz_adres_o), 128'(v.eyaz));
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_i = 1'b0; istek_i = 1'b0; istek_adres_i = 32'd0;
        bellek_veri_i = 32'd0; bellek_gecerli_i = 1'b0;

`ifdef KRITIK_KELIME_ILK_EN
        set_vec(0, 32'h0000_1234, 0, 4, 32'h1234, 32'h1238, 32'h123C, 32'h1230, OBEK_A, 32'h1230, 5, 1, 0);
        set_vec(1, 32'h0000_1238, 0, 4, 32'h1238, 32'h123C, 32'h1230, 32'h1234, OBEK_A, 32'h1230, 5, 1, 0);
        set_vec(3, 32'h0000_2004, 0, 2, 32'h2004, 32'h2008, 32'h200C, 32'h2000, OBEK_A, 32'h1230, 11, 0, 1);
        set_vec(4, 32'h0000_4ABC, 1, 4, 32'h4ABC, 32'h4AB0, 32'h4AB4, 32'h4AB8,
                {32'hC0DE_4ABC, 32'hC0DE_4AB8, 32'hC0DE_4AB4, 32'hC0DE_4AB0}, 32'h4AB0, 9, 1, 0);
        set_vec(5, 32'hFFFF_FFF8, 0, 4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF4,
                {32'h3F21_FFFC, 32'h3F21_FFF8, 32'h3F21_FFF4, 32'h3F21_FFF0}, 32'hFFFF_FFF0, 5, 1, 0);
`else
        set_vec(0, 32'h0000_1234, 0, 4, 32'h1230, 32'h1234, 32'h1238, 32'h123C, OBEK_A, 32'h1230, 5, 1, 0);
        set_vec(1, 32'h0000_1238, 0, 4, 32'h1230, 32'h1234, 32'h1238, 32'h123C, OBEK_A, 32'h1230, 5, 1, 0);
        set_vec(3, 32'h0000_2004, 0, 2, 32'h2000, 32'h2004, 32'h2008, 32'h200C, OBEK_A, 32'h1230, 11, 0, 1);
        set_vec(4, 32'h0000_4ABC, 1, 4, 32'h4AB0, 32'h4AB4, 32'h4AB8, 32'h4ABC,
                {32'hC0DE_4ABC, 32'hC0DE_4AB8, 32'hC0DE_4AB4, 32'hC0DE_4AB0}, 32'h4AB0, 9, 1, 0);
        set_vec(5, 32'hFFFF_FFF8, 0, 4, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
                {32'h3F21_FFFC, 32'h3F21_FFF8, 32'h3F21_FFF4, 32'h3F21_FFF0}, 32'hFFFF_FFF0, 5, 1, 0);
`endif
        set_vec(2, 32'h0000_1230, 3, 4, 32'h1230, 32'h1234, 32'h1238, 32'h123C, OBEK_A, 32'h1230, 17, 1, 0);
        set_vec(6, 32'h0000_2000, 0, 4, 32'h2000, 32'h2004, 32'h2008, 32'h200C,
                {32'hC0DE_200C, 32'hC0DE_2008, 32'hC0DE_2004, 32'hC0DE_2000}, 32'h2000, 5, 1, 0);

        // Reset state.
        tick(); tick();
        chk("rst.oku", 128'(bellek_oku_o), 128'd0);
        chk("rst.adres", 128'(bellek_adres_o), 128'd0);
        chk("rst.obek", buyruk_obek_o, 128'd0);
        chk("rst.geldi", 128'(obek_geldi_o), 128'd0);
        chk("rst.yaz_adres", 128'(onbellek_yaz_adres_o), 128'd0);
        chk("rst.mesgul", 128'(mesgul_o), 128'd0);
        chk("rst.hata", 128'(hata_o), 128'd0);
        rst_i = 1'b1;
        tick();
        chk("idle.mesgul", 128'(mesgul_o), 128'd0);

        // Table-driven refills (entry 6 is used after the reset sequence).
        for (int i = 0; i < 6; i++) do_refill(vt[i], 1'b0, $sformatf("v%0d", i));

        // Request held high through refill and TAMAM: no restart until BOSTA.
        do_refill(vt[0], 1'b1, "hold");
        tick();                                // request accepted again only now
        istek_i = 1'b0;
        chk("hold.restart_mesgul", 128'(mesgul_o), 128'd1);
        chk("hold.restart_oku", 128'(bellek_oku_o), 128'd1);
        chk("hold.restart_adres", 128'(bellek_adres_o), 128'(vt[0].ea[0]));

        // Two words land, then asynchronous reset in the middle of the refill.
        for (int w = 0; w < 2; w++) begin
            bellek_gecerli_i = 1'b1;
            bellek_veri_i    = mem(bellek_adres_o);
            tick();
        end
        #2;
        rst_i            = 1'b0;
        bellek_veri_i    = 32'hDEAD_BEEF;
        #1;
        chk("mrst.mesgul", 128'(mesgul_o), 128'd0);
        chk("mrst.oku", 128'(bellek_oku_o), 128'd0);
        chk("mrst.obek", buyruk_obek_o, 128'd0);
        chk("mrst.yaz_adres", 128'(onbellek_yaz_adres_o), 128'd0);
        tick(); tick();
        rst_i = 1'b1;                          // stray valid words keep coming
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mrst.after_mesgul", 128'(mesgul_o), 128'd0);
            chk("mrst.after_geldi", 128'(obek_geldi_o), 128'd0);
            chk("mrst.after_hata", 128'(hata_o), 128'd0);
        end
        bellek_gecerli_i = 1'b0;
        do_refill(vt[6], 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
